move_stack_ctrl: RTL and testbench

MOVE_STACK_CTRL -- requirements
Module: move_stack_ctrl

---
 rtl/move_stack_ctrl_if.sv | 36 +++
 rtl/move_stack_ctrl.sv | 123 ++++++++++++
 tb/tb_move_stack_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_stack_ctrl_if.sv
// Move-stack controller bus: rx generator handshake, stack write/read ports, status.
// Latency: none, plain signal bundle.
// Backpressure: none; the controller paces rx through collect_pieces and a fixed wait.
interface move_stack_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 16
);
    logic                  start;
    logic                  collect_pieces;
    logic [LANES*16-1:0]   formatted_moves;
    logic [LANES-1:0]      stack_write;
    logic                  stack_wr_en;
    logic [ADDR_W-1:0]     stack_wr_addr;
    logic [15:0]           stack_wr_data;
    logic                  pop;
    logic                  stack_rd_en;
    logic [ADDR_W-1:0]     stack_rd_addr;
    logic [ADDR_W:0]       count;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    // Controller side
    modport slave (
        input  start, formatted_moves, stack_write, pop,
        output collect_pieces, stack_wr_en, stack_wr_addr, stack_wr_data,
               stack_rd_en, stack_rd_addr, count, busy, done, overflow
    );

    // Requester / rx / stack side
    modport master (
        output start, formatted_moves, stack_write, pop,
        input  collect_pieces, stack_wr_en, stack_wr_addr, stack_wr_data,
               stack_rd_en, stack_rd_addr, count, busy, done, overflow
    );
endinterface

// File: rtl/move_stack_ctrl.sv
// Runs one move-generation pass: strobes rx, latches its lanes, pushes valid lanes onto the move stack; pops top entry when idle.
// Latency: done 4 cycles after start for an empty pass, plus one cycle per valid lane.
// Backpressure: none; start while busy is dropped, pop outside IDLE is dropped, writes to a full stack are dropped and flagged.
module move_stack_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    move_stack_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WAIT, S_LATCH, S_DRAIN, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [LANES*16-1:0]   moves_q, moves_d;

    logic [LANES-1:0]      lowest;
    logic                  last_bit;
    logic                  full;
    logic                  drain_wr;
    logic                  pop_ok;
    logic [15:0]           lane_dat;

    // The count reaches DEPTH exactly when its top bit is set.
    assign full     = count_q[ADDR_W];
    assign lowest   = mask_q & (~mask_q + LANES'(1));
    assign last_bit = (mask_q & (mask_q - LANES'(1))) == '0;
    assign drain_wr = (state_q == S_DRAIN) && !full;
    assign pop_ok   = (state_q == S_IDLE) && bus.pop && !bus.start && (count_q != '0);

    // Pick the data of the lowest pending lane.
    always_comb begin
        lane_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lowest[i]) begin
                lane_dat = moves_q[i*16 +: 16];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed collect/wait/latch sequence, then one drain cycle per valid lane.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = S_COLLECT;
            S_COLLECT: state_d = S_WAIT;
            S_WAIT:    state_d = S_LATCH;
            S_LATCH:   state_d = (bus.stack_write != '0) ? S_DRAIN : S_DONE;
            S_DRAIN:   if (last_bit) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode; only the read port looks at pop combinationally.
    always_comb begin
        bus.collect_pieces = (state_q == S_COLLECT);
        bus.busy           = (state_q != S_IDLE);
        bus.done           = (state_q == S_DONE);
        bus.stack_wr_en    = drain_wr;
        bus.stack_wr_addr  = drain_wr ? count_q[ADDR_W-1:0] : '0;
        bus.stack_wr_data  = drain_wr ? lane_dat : '0;
        bus.stack_rd_en    = pop_ok;
        bus.stack_rd_addr  = pop_ok ? (count_q[ADDR_W-1:0] - ADDR_W'(1)) : '0;
        bus.count          = count_q;
        bus.overflow       = ovf_q;
    end

    // Datapath next-state: occupancy, sticky overflow, captured lanes.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        mask_d  = mask_q;
        moves_d = moves_q;
        if (drain_wr) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop_ok) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        if ((state_q == S_IDLE) && bus.start) begin
            ovf_d = 1'b0;
        end else if ((state_q == S_DRAIN) && full) begin
            ovf_d = 1'b1;
        end
        if (state_q == S_LATCH) begin
            mask_d  = bus.stack_write;
            moves_d = bus.formatted_moves;
        end else if (state_q == S_DRAIN) begin
            mask_d  = mask_q & ~lowest;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= '0;
            moves_q <= '0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
            moves_q <= moves_d;
        end
    end

endmodule

// File: tb/tb_move_stack_ctrl.sv
module tb_move_stack_ctrl;
    localparam int ADDR_W = 8;
    localparam int LANES  = 16;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_stack_ctrl_if #(.ADDR_W(ADDR_W), .LANES(LANES)) bus();

    move_stack_ctrl #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: a timeline of expected cycles per pass ----------------
    typedef struct {
        bit        collect;
        bit        latch;
        bit        wr;
        bit [7:0]  addr;
        bit [15:0] data;
        bit        drop;
        bit        dn;
    } step_t;

    step_t plan[$];
    step_t s;
    int    m_count = 0;
    bit    m_ovf   = 0;
    int    start_cyc = 0;

    int wr_addr_log[$];
    int wr_data_log[$];
    int rd_log[$];
    int done_log[$];

    function automatic step_t mk(bit c, bit l, bit w, int a, logic [15:0] d, bit dr, bit dn);
        step_t r;
        r.collect = c; r.latch = l; r.wr = w; r.addr = a[7:0];
        r.data = d; r.drop = dr; r.dn = dn;
        return r;
    endfunction

    // Valid lanes go out lowest-first; anything beyond DEPTH is dropped.
    function automatic void build(logic [15:0] sw, logic [255:0] mv);
        int c = m_count;
        for (int i = 0; i < LANES; i++) begin
            if (sw[i]) begin
                if (c < DEPTH) begin
                    plan.push_back(mk(0, 0, 1, c, mv[i*16 +: 16], 0, 0));
                    c++;
                end else begin
                    plan.push_back(mk(0, 0, 0, 0, 16'h0, 1, 0));
                end
            end
        end
        plan.push_back(mk(0, 0, 0, 0, 16'h0, 0, 1));
    endfunction

    bit          e_collect, e_wr, e_rd, e_busy, e_done, e_ovf;
    logic [7:0]  e_addr, e_raddr;
    logic [15:0] e_data;
    int          e_count;

    always @(negedge clk) begin
        cyc++;
        e_collect = 0; e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0;
        e_addr = 0; e_raddr = 0; e_data = 0;
        if (rst) begin
            plan.delete();
            m_count = 0;
            m_ovf   = 0;
            e_count = 0;
            e_ovf   = 0;
        end else begin
            e_count = m_count;
            e_ovf   = m_ovf;
            if (plan.size() > 0) begin
                s = plan.pop_front();
                e_busy = 1; e_collect = s.collect; e_wr = s.wr;
                e_addr = s.addr; e_data = s.data; e_done = s.dn;
                if (s.latch) build(bus.stack_write, bus.formatted_moves);
                if (s.wr) m_count++;
                if (s.drop) m_ovf = 1;
            end else if (bus.start) begin
                plan.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0));
                plan.push_back(mk(0, 0, 0, 0, 16'h0, 0, 0));
                plan.push_back(mk(0, 1, 0, 0, 16'h0, 0, 0));
                m_ovf = 0;
                start_cyc = cyc;
            end else if (bus.pop && m_count > 0) begin
                e_rd = 1;
                e_raddr = 8'(m_count - 1);
                m_count--;
            end
        end
        check("collect_pieces", 32'(bus.collect_pieces), 32'(e_collect));
        check("stack_wr_en",    32'(bus.stack_wr_en),    32'(e_wr));
        check("stack_wr_addr",  32'(bus.stack_wr_addr),  32'(e_addr));
        check("stack_wr_data",  32'(bus.stack_wr_data),  32'(e_data));
        check("stack_rd_en",    32'(bus.stack_rd_en),    32'(e_rd));
        check("stack_rd_addr",  32'(bus.stack_rd_addr),  32'(e_raddr));
        check("busy",           32'(bus.busy),           32'(e_busy));
        check("done",           32'(bus.done),           32'(e_done));
        check("count",          32'(bus.count),          32'(e_count));
        check("overflow",       32'(bus.overflow),       32'(e_ovf));
        if (bus.stack_wr_en) begin
            wr_addr_log.push_back(int'(bus.stack_wr_addr));
            wr_data_log.push_back(int'(bus.stack_wr_data));
        end
        if (bus.stack_rd_en) rd_log.push_back(int'(bus.stack_rd_addr));
        if (bus.done) done_log.push_back(cyc);
    end

    // ---------------- stimulus ----------------
    logic [255:0] junk;
    logic [255:0] mv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete(); wr_data_log.delete(); rd_log.delete(); done_log.delete();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            if (!bus.busy) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle timeout busy still high cycle=%0d", cyc);
    endtask

    // Garbage on the rx inputs everywhere except the LATCH cycle; a second start in WAIT.
    task automatic run_pass(input logic [15:0] sw, input logic [255:0] moves,
                            input bit pop_with_start, input bit pop_in_drain);
        bus.start = 1'b1; bus.pop = pop_with_start; tick();   // IDLE, start accepted
        bus.start = 1'b0; bus.pop = 1'b0; tick();             // COLLECT
        bus.start = 1'b1; tick();                             // WAIT, start ignored
        bus.start = 1'b0; bus.stack_write = sw; bus.formatted_moves = moves; tick(); // LATCH
        bus.stack_write = 16'hA5A5; bus.formatted_moves = junk;
        if (pop_in_drain) begin
            bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        junk = {16{16'hDEAD}};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pop = 1'b0;
        bus.stack_write = 16'hA5A5;
        bus.formatted_moves = junk;
        repeat (3) tick();
        check("reset_count", 32'(bus.count), 0);
        check("reset_busy",  32'(bus.busy), 0);
        rst = 1'b0;
        tick();

        // Empty pass
        clear_logs();
        run_pass(16'h0000, junk, 0, 0);
        check("empty_writes", 32'(wr_addr_log.size()), 0);
        check("empty_done_n", 32'(done_log.size()), 1);
        if (done_log.size() == 1) check("empty_done_lat", 32'(done_log[0] - start_cyc), 4);
        check("empty_count", 32'(bus.count), 0);

        // Sparse pass: lanes 0, 2, 15
        clear_logs();
        mv = {16{16'h7777}};
        mv[15:0] = 16'h1111; mv[47:32] = 16'h2222; mv[255:240] = 16'hFFFF;
        run_pass(16'h8005, mv, 0, 0);
        check("sparse_nwr", 32'(wr_addr_log.size()), 3);
        if (wr_addr_log.size() == 3) begin
            check("sparse_a0", 32'(wr_addr_log[0]), 0);
            check("sparse_a2", 32'(wr_addr_log[2]), 2);
            check("sparse_d0", 32'(wr_data_log[0]), 32'h1111);
            check("sparse_d1", 32'(wr_data_log[1]), 32'h2222);
            check("sparse_d2", 32'(wr_data_log[2]), 32'hFFFF);
        end
        check("sparse_count", 32'(bus.count), 3);

        // Pop down to empty and one past
        clear_logs();
        bus.pop = 1'b1;
        repeat (4) tick();
        bus.pop = 1'b0;
        tick();
        check("pop_nrd", 32'(rd_log.size()), 3);
        if (rd_log.size() == 3) begin
            check("pop_r0", 32'(rd_log[0]), 2);
            check("pop_r1", 32'(rd_log[1]), 1);
            check("pop_r2", 32'(rd_log[2]), 0);
        end
        check("pop_count", 32'(bus.count), 0);

        // Fill to 250, then overflow pass
        for (int p = 0; p < 15; p++) run_pass(16'hFFFF, junk, 0, 0);
        run_pass(16'h03FF, junk, 0, 0);
        check("fill_count", 32'(bus.count), 250);
        clear_logs();
        run_pass(16'hFFFF, junk, 0, 0);
        check("ovf_nwr", 32'(wr_addr_log.size()), 6);
        if (wr_addr_log.size() == 6) begin
            check("ovf_first", 32'(wr_addr_log[0]), 250);
            check("ovf_last",  32'(wr_addr_log[5]), 255);
        end
        check("ovf_count", 32'(bus.count), 256);
        check("ovf_flag", 32'(bus.overflow), 1);
        repeat (3) tick();
        check("ovf_sticky", 32'(bus.overflow), 1);

        // Contention: start+pop together, pop during DRAIN
        bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        check("pre_cont_count", 32'(bus.count), 255);
        clear_logs();
        mv = junk;
        mv[15:0] = 16'hBEEF;
        run_pass(16'h0001, mv, 1, 1);
        check("cont_nrd", 32'(rd_log.size()), 0);
        check("cont_nwr", 32'(wr_addr_log.size()), 1);
        if (wr_addr_log.size() == 1) begin
            check("cont_addr", 32'(wr_addr_log[0]), 255);
            check("cont_data", 32'(wr_data_log[0]), 32'hBEEF);
        end
        check("cont_count", 32'(bus.count), 256);
        check("cont_ovf", 32'(bus.overflow), 0);

        // Reset after 2 of 5 drain writes
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("rst2_count", 32'(bus.count), 0);
        clear_logs();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        tick();
        bus.stack_write = 16'h001F; bus.formatted_moves = junk; tick();
        bus.stack_write = 16'hA5A5;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_count", 32'(bus.count), 0);
        check("abort_busy",  32'(bus.busy), 0);
        check("abort_wr_en", 32'(bus.stack_wr_en), 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("abort_nwr",  32'(wr_addr_log.size()), 2);
        check("abort_done", 32'(done_log.size()), 0);
        check("abort_count_after", 32'(bus.count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
